// File: rtl/pc_control.sv
// Program-counter sequencing FSM: continuous run, single-step, halt.
// Optional single-step mode is built only when PC_CONTROL_STEP_EN is defined.
module pc_control #(
    parameter int CONTADOR_LENGTH    = 11,
    parameter int CYCLE_COUNT_LENGTH = 32
) (
    input  logic                          i_clock,
    input  logic                          i_soft_reset,
    input  logic                          i_start,
    input  logic                          i_modo,
    input  logic                          i_step,
    input  logic                          i_stall,
    input  logic [CONTADOR_LENGTH-1:0]    i_pc_actual,
    input  logic                          i_jump,
    input  logic [CONTADOR_LENGTH-1:0]    i_jump_target,
    input  logic                          i_branch_taken,
    input  logic [CONTADOR_LENGTH-1:0]    i_branch_target,
    input  logic                          i_halt,
    output logic [CONTADOR_LENGTH-1:0]    o_direccion,
    output logic                          o_enable_pc,
    output logic [1:0]                    o_estado,
    output logic                          o_halted,
    output logic [CYCLE_COUNT_LENGTH-1:0] o_ciclos
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RUN       = 2'b01,
        STEP_WAIT = 2'b10,
        HALT      = 2'b11
    } state_t;

    localparam logic [CONTADOR_LENGTH-1:0] PC_ONE =
        {{(CONTADOR_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [CYCLE_COUNT_LENGTH-1:0] CYC_ONE =
        {{(CYCLE_COUNT_LENGTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t next_state;
    logic   enable_pc;
    logic [CYCLE_COUNT_LENGTH-1:0] ciclos;

`ifdef PC_CONTROL_STEP_EN
    logic step_q;
    logic pending;
    logic step_rise;

    assign step_rise = i_step & ~step_q;

    // Pending clears whenever it is consumed (advance or halt); edges
    // arriving while a request is already pending merge into it.
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            step_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            step_q <= i_step;
            if (state != STEP_WAIT)
                pending <= 1'b0;
            else if (pending & ~i_stall)
                pending <= 1'b0;
            else if (step_rise)
                pending <= 1'b1;
        end
    end
`else
    logic unused_step;
    assign unused_step = i_modo ^ i_step;
`endif

    always_ff @(posedge i_clock) begin
        if (i_soft_reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        enable_pc  = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start) begin
`ifdef PC_CONTROL_STEP_EN
                    next_state = i_modo ? STEP_WAIT : RUN;
`else
                    next_state = RUN;
`endif
                end
            end
            RUN: begin
                enable_pc = ~i_stall & ~i_halt;
                if (i_halt & ~i_stall)
                    next_state = HALT;
            end
            STEP_WAIT: begin
`ifdef PC_CONTROL_STEP_EN
                enable_pc = pending & ~i_stall & ~i_halt;
                if (pending & i_halt & ~i_stall)
                    next_state = HALT;
`else
                next_state = IDLE;
`endif
            end
            HALT: begin
                next_state = HALT;
            end
        endcase
        if (i_soft_reset)
            enable_pc = 1'b0;
    end

    always_ff @(posedge i_clock) begin
        if (i_soft_reset)
            ciclos <= '0;
        else if (enable_pc && (ciclos != '1))
            ciclos <= ciclos + CYC_ONE;
    end

    // Jump outranks branch; sequential address wraps at the top.
    always_comb begin
        if (i_jump)
            o_direccion = i_jump_target;
        else if (i_branch_taken)
            o_direccion = i_branch_target;
        else
            o_direccion = i_pc_actual + PC_ONE;
    end

    assign o_enable_pc = enable_pc;
    assign o_estado    = state;
    assign o_halted    = (state == HALT);
    assign o_ciclos    = ciclos;

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: table-driven rows, scoreboard queue.
// Step-mode scenario is built when PC_CONTROL_STEP_EN is defined.
module tb_pc_control;

    logic        i_clock;
    logic        i_soft_reset;
    logic        i_start;
    logic        i_modo;
    logic        i_step;
    logic        i_stall;
    logic [10:0] i_pc_actual;
    logic        i_jump;
    logic [10:0] i_jump_target;
    logic        i_branch_taken;
    logic [10:0] i_branch_target;
    logic        i_halt;
    logic [10:0] o_direccion;
    logic        o_enable_pc;
    logic [1:0]  o_estado;
    logic        o_halted;
    logic [31:0] o_ciclos;

    pc_control dut (
        .i_clock         (i_clock),
        .i_soft_reset    (i_soft_reset),
        .i_start         (i_start),
        .i_modo          (i_modo),
        .i_step          (i_step),
        .i_stall         (i_stall),
        .i_pc_actual     (i_pc_actual),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_halt          (i_halt),
        .o_direccion     (o_direccion),
        .o_enable_pc     (o_enable_pc),
        .o_estado        (o_estado),
        .o_halted        (o_halted),
        .o_ciclos        (o_ciclos)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic [10:0] dir;
        logic        en;
        logic [1:0]  st;
        logic        hl;
        logic [31:0] cyc;
    } exp_t;

    // ctl bits: {rst, start, modo, step, stall, halt, jump, br}
    typedef struct packed {
        logic [7:0]  ctl;
        logic [10:0] pc;
        logic [10:0] jt;
        logic [10:0] bt;
        exp_t        x;
    } row_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic row_t mk(input logic [7:0] ctl,
                                input logic [10:0] pc,
                                input logic [10:0] jt,
                                input logic [10:0] bt,
                                input logic [10:0] dir,
                                input logic en,
                                input logic [1:0] st,
                                input logic hl,
                                input int cyc);
        row_t r;
        r.ctl   = ctl;
        r.pc    = pc;
        r.jt    = jt;
        r.bt    = bt;
        r.x.dir = dir;
        r.x.en  = en;
        r.x.st  = st;
        r.x.hl  = hl;
        r.x.cyc = cyc;
        return r;
    endfunction

    task automatic drive(input row_t r);
        {i_soft_reset, i_start, i_modo, i_step,
         i_stall, i_halt, i_jump, i_branch_taken} = r.ctl;
        i_pc_actual     = r.pc;
        i_jump_target   = r.jt;
        i_branch_target = r.bt;
        sb.push_back(r.x);
    endtask

    task automatic do_reset();
        drive(mk(8'b1000_0000, 0, 0, 0, 1, 0, 0, 0, 0));
        void'(sb.pop_front());
        @(posedge i_clock); #1;
    endtask

    task automatic test_reset();
        row_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(8'b1101_0100, 11'h005, 0, 0, 11'h006, 0, 0, 0, 0));
        t.push_back(mk(8'b0000_0000, 11'h010, 0, 0, 11'h011, 0, 0, 0, 0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge i_clock);
            e = sb.pop_front();
            n_cmp++;
            if ({o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos} !== e) begin
                n_bad++;
                $display("FAIL reset[%0d]: got dir=%h en=%b st=%b hl=%b cyc=%0d want dir=%h en=%b st=%b hl=%b cyc=%0d",
                    i, o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos,
                    e.dir, e.en, e.st, e.hl, e.cyc);
            end
            @(posedge i_clock); #1;
        end
    endtask

    task automatic test_run_sequence();
        row_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(8'b0100_0000, 11'h000, 0, 0, 11'h001, 0, 0, 0, 0));
        t.push_back(mk(8'b0000_0000, 11'h000, 0, 0, 11'h001, 1, 1, 0, 0));
        t.push_back(mk(8'b0000_0000, 11'h001, 0, 0, 11'h002, 1, 1, 0, 1));
        t.push_back(mk(8'b0000_0000, 11'h002, 0, 0, 11'h003, 1, 1, 0, 2));
        t.push_back(mk(8'b0000_1000, 11'h003, 0, 0, 11'h004, 0, 1, 0, 3));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge i_clock);
            e = sb.pop_front();
            n_cmp++;
            if ({o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos} !== e) begin
                n_bad++;
                $display("FAIL run_seq[%0d]: got dir=%h en=%b st=%b hl=%b cyc=%0d want dir=%h en=%b st=%b hl=%b cyc=%0d",
                    i, o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos,
                    e.dir, e.en, e.st, e.hl, e.cyc);
            end
            @(posedge i_clock); #1;
        end
    endtask

    task automatic test_wrap_priority();
        row_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(8'b0100_0000, 11'h000, 0, 0, 11'h001, 0, 0, 0, 0));
        t.push_back(mk(8'b0000_0000, 11'h7FF, 0, 0, 11'h000, 1, 1, 0, 0));
        t.push_back(mk(8'b0000_0011, 11'h000, 11'h040, 11'h080, 11'h040, 1, 1, 0, 1));
        t.push_back(mk(8'b0000_0001, 11'h040, 11'h040, 11'h080, 11'h080, 1, 1, 0, 2));
        t.push_back(mk(8'b0000_1011, 11'h080, 11'h040, 11'h080, 11'h040, 0, 1, 0, 3));
        t.push_back(mk(8'b0000_1011, 11'h080, 11'h040, 11'h080, 11'h040, 0, 1, 0, 3));
        t.push_back(mk(8'b0000_0000, 11'h080, 0, 0, 11'h081, 1, 1, 0, 3));
        t.push_back(mk(8'b0000_1100, 11'h081, 0, 0, 11'h082, 0, 1, 0, 4));
        t.push_back(mk(8'b0000_0000, 11'h081, 0, 0, 11'h082, 1, 1, 0, 4));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge i_clock);
            e = sb.pop_front();
            n_cmp++;
            if ({o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos} !== e) begin
                n_bad++;
                $display("FAIL wrap_prio[%0d]: got dir=%h en=%b st=%b hl=%b cyc=%0d want dir=%h en=%b st=%b hl=%b cyc=%0d",
                    i, o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos,
                    e.dir, e.en, e.st, e.hl, e.cyc);
            end
            @(posedge i_clock); #1;
        end
    endtask

    task automatic test_halt();
        row_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(8'b0100_0000, 11'h000, 0, 0, 11'h001, 0, 0, 0, 0));
        t.push_back(mk(8'b0000_0000, 11'h005, 0, 0, 11'h006, 1, 1, 0, 0));
        t.push_back(mk(8'b0000_0100, 11'h006, 0, 0, 11'h007, 0, 1, 0, 1));
        t.push_back(mk(8'b0100_0000, 11'h006, 0, 0, 11'h007, 0, 3, 1, 1));
        t.push_back(mk(8'b0000_0000, 11'h006, 0, 0, 11'h007, 0, 3, 1, 1));
        t.push_back(mk(8'b1100_0000, 11'h006, 0, 0, 11'h007, 0, 3, 1, 1));
        t.push_back(mk(8'b0000_0000, 11'h006, 0, 0, 11'h007, 0, 0, 0, 0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge i_clock);
            e = sb.pop_front();
            n_cmp++;
            if ({o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos} !== e) begin
                n_bad++;
                $display("FAIL halt[%0d]: got dir=%h en=%b st=%b hl=%b cyc=%0d want dir=%h en=%b st=%b hl=%b cyc=%0d",
                    i, o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos,
                    e.dir, e.en, e.st, e.hl, e.cyc);
            end
            @(posedge i_clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        row_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(8'b0100_0000, 11'h000, 0, 0, 11'h001, 0, 0, 0, 0));
        t.push_back(mk(8'b0000_0000, 11'h000, 0, 0, 11'h001, 1, 1, 0, 0));
        t.push_back(mk(8'b0000_0000, 11'h001, 0, 0, 11'h002, 1, 1, 0, 1));
        t.push_back(mk(8'b1001_0100, 11'h002, 0, 0, 11'h003, 0, 1, 0, 2));
        t.push_back(mk(8'b0100_0000, 11'h002, 0, 0, 11'h003, 0, 0, 0, 0));
        t.push_back(mk(8'b0000_0000, 11'h002, 0, 0, 11'h003, 1, 1, 0, 0));
        t.push_back(mk(8'b0000_0000, 11'h003, 0, 0, 11'h004, 1, 1, 0, 1));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge i_clock);
            e = sb.pop_front();
            n_cmp++;
            if ({o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos} !== e) begin
                n_bad++;
                $display("FAIL back2back[%0d]: got dir=%h en=%b st=%b hl=%b cyc=%0d want dir=%h en=%b st=%b hl=%b cyc=%0d",
                    i, o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos,
                    e.dir, e.en, e.st, e.hl, e.cyc);
            end
            @(posedge i_clock); #1;
        end
    endtask

`ifdef PC_CONTROL_STEP_EN
    task automatic test_step();
        row_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(8'b0110_0000, 11'h000, 0, 0, 11'h001, 0, 0, 0, 0));
        t.push_back(mk(8'b0000_0000, 11'h000, 0, 0, 11'h001, 0, 2, 0, 0));
        t.push_back(mk(8'b0001_0000, 11'h000, 0, 0, 11'h001, 0, 2, 0, 0));
        t.push_back(mk(8'b0001_0000, 11'h000, 0, 0, 11'h001, 1, 2, 0, 0));
        t.push_back(mk(8'b0001_0000, 11'h001, 0, 0, 11'h002, 0, 2, 0, 1));
        t.push_back(mk(8'b0001_0000, 11'h001, 0, 0, 11'h002, 0, 2, 0, 1));
        t.push_back(mk(8'b0001_0000, 11'h001, 0, 0, 11'h002, 0, 2, 0, 1));
        t.push_back(mk(8'b0000_0000, 11'h001, 0, 0, 11'h002, 0, 2, 0, 1));
        t.push_back(mk(8'b0001_1000, 11'h001, 0, 0, 11'h002, 0, 2, 0, 1));
        t.push_back(mk(8'b0000_1000, 11'h001, 0, 0, 11'h002, 0, 2, 0, 1));
        t.push_back(mk(8'b0001_1000, 11'h001, 0, 0, 11'h002, 0, 2, 0, 1));
        t.push_back(mk(8'b0001_0000, 11'h001, 0, 0, 11'h002, 1, 2, 0, 1));
        t.push_back(mk(8'b0001_0000, 11'h002, 0, 0, 11'h003, 0, 2, 0, 2));
        t.push_back(mk(8'b0000_0000, 11'h002, 0, 0, 11'h003, 0, 2, 0, 2));
        t.push_back(mk(8'b0001_0000, 11'h002, 0, 0, 11'h003, 0, 2, 0, 2));
        t.push_back(mk(8'b0001_0100, 11'h002, 0, 0, 11'h003, 0, 2, 0, 2));
        t.push_back(mk(8'b0001_0000, 11'h002, 0, 0, 11'h003, 0, 3, 1, 2));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge i_clock);
            e = sb.pop_front();
            n_cmp++;
            if ({o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos} !== e) begin
                n_bad++;
                $display("FAIL step[%0d]: got dir=%h en=%b st=%b hl=%b cyc=%0d want dir=%h en=%b st=%b hl=%b cyc=%0d",
                    i, o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos,
                    e.dir, e.en, e.st, e.hl, e.cyc);
            end
            @(posedge i_clock); #1;
        end
    endtask
`else
    task automatic test_no_step();
        row_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(8'b0110_0000, 11'h000, 0, 0, 11'h001, 0, 0, 0, 0));
        t.push_back(mk(8'b0011_0000, 11'h000, 0, 0, 11'h001, 1, 1, 0, 0));
        t.push_back(mk(8'b0011_0000, 11'h001, 0, 0, 11'h002, 1, 1, 0, 1));
        t.push_back(mk(8'b0010_0000, 11'h002, 0, 0, 11'h003, 1, 1, 0, 2));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge i_clock);
            e = sb.pop_front();
            n_cmp++;
            if ({o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos} !== e) begin
                n_bad++;
                $display("FAIL no_step[%0d]: got dir=%h en=%b st=%b hl=%b cyc=%0d want dir=%h en=%b st=%b hl=%b cyc=%0d",
                    i, o_direccion, o_enable_pc, o_estado, o_halted, o_ciclos,
                    e.dir, e.en, e.st, e.hl, e.cyc);
            end
            @(posedge i_clock); #1;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(mk(8'b1000_0000, 0, 0, 0, 1, 0, 0, 0, 0));
        void'(sb.pop_front());
        @(posedge i_clock); #1;
        test_reset();
        test_run_sequence();
        test_wrap_priority();
        test_halt();
        test_back_to_back();
`ifdef PC_CONTROL_STEP_EN
        test_step();
`else
        test_no_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_control.md
PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 Parameter CONTADOR_LENGTH, default 11: width of instruction-memory address / PC.
REQ-002 Parameter CYCLE_COUNT_LENGTH, default 32: width of executed-cycle counter.
REQ-003 i_clock  in  1  single clock; all state updates on rising edge.
REQ-004 i_soft_reset  in  1  reset, synchronous, active-high.
REQ-005 i_start  in  1  level; begin program execution from IDLE.
REQ-006 i_modo  in  1  execution mode sampled on start: 0 continuous, 1 step.
REQ-007 i_step  in  1  step request from debug unit; a rising edge requests one advance.
REQ-008 i_stall  in  1  hazard-unit stall; PC must hold.
REQ-009 i_pc_actual  in  CONTADOR_LENGTH  current PC register value.
REQ-010 i_jump, i_jump_target  in  1, CONTADOR_LENGTH  jump request and target.
REQ-011 i_branch_taken, i_branch_target  in  1, CONTADOR_LENGTH  taken branch and target.
REQ-012 i_halt  in  1  HALT instruction decoded.
REQ-013 o_direccion  out  CONTADOR_LENGTH  next PC value to the PC register.
REQ-014 o_enable_pc  out  1  load strobe to the PC register.
REQ-015 o_estado  out  2  FSM state encoding; o_halted  out  1  high in HALT.
REQ-016 o_ciclos  out  CYCLE_COUNT_LENGTH  count of PC advances since reset.

Function
REQ-017 FSM states: IDLE=00, RUN=01, STEP_WAIT=10, HALT=11; o_estado equals current state.
REQ-018 IDLE: o_enable_pc=0; i_start=1 -> RUN if i_modo=0, else STEP_WAIT.
REQ-019 o_direccion, combinational: i_jump ? i_jump_target : i_branch_taken ? i_branch_target : i_pc_actual+1, jump priority over branch.
REQ-020 PC+1 wraps modulo 2^CONTADOR_LENGTH (all-ones -> 0), no carry out.
REQ-021 RUN: o_enable_pc = ~i_stall & ~i_halt, combinational, zero latency.
REQ-022 RUN with i_halt=1 and i_stall=0 -> HALT next edge; PC not loaded that cycle; i_halt while stalled ignored.
REQ-023 STEP_WAIT: registered edge detector on i_step sets a pending flag; i_step held high produces exactly one advance.
REQ-024 STEP_WAIT: o_enable_pc = pending & ~i_stall & ~i_halt; pending clears on the cycle o_enable_pc=1; pending persists through stall.
REQ-025 STEP_WAIT: pending & i_halt & ~i_stall -> HALT, pending cleared; new i_step edges while pending already set are absorbed.
REQ-026 HALT: o_enable_pc=0, o_halted=1; remains until reset; i_start ignored.
REQ-027 o_ciclos increments by 1 on each cycle with o_enable_pc=1; saturates at all-ones.
REQ-028 i_modo sampled only on IDLE exit; changes afterwards have no effect.

Reset
REQ-029 i_soft_reset=1 at an edge: state IDLE, pending=0, step edge register=0, o_ciclos=0, o_halted=0.
REQ-030 During reset cycle o_enable_pc=0; reset overrides i_start, i_step and i_halt in any state, mid-run included.

Configuration
REQ-031 Macro PC_CONTROL_STEP_EN defined: step mode per REQ-006/018/023-025.
REQ-032 Macro undefined: STEP_WAIT unreachable, i_modo and i_step ignored, i_start always -> RUN; encoding 10 never produced.

Verification
REQ-033 Reset, i_start=1, i_modo=0, i_pc_actual tracking o_direccion from 0 -> addresses 1,2,3,... one per cycle; o_ciclos=3 after 3 cycles.
REQ-034 RUN, i_pc_actual=0x7FF, no jump/branch -> o_direccion=0x000, o_enable_pc=1.
REQ-035 RUN, i_jump=1 target 0x040 and i_branch_taken=1 target 0x080 same cycle -> o_direccion=0x040; i_stall=1 -> o_enable_pc=0, o_ciclos unchanged.
REQ-036 STEP_EN, i_modo=1, i_step high for 5 cycles -> exactly one o_enable_pc pulse; step edge during 3-cycle stall -> pulse on first unstalled cycle.
REQ-037 RUN, i_halt=1 -> o_enable_pc=0 that cycle, o_estado=11, o_halted=1 next; i_start pulse ignored; i_soft_reset=1 -> o_estado=00, o_ciclos=0.
REQ-038 STEP_EN undefined: i_start with i_modo=1 -> o_estado=01, continuous advance.
